// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse stream decoder: 11-bit frames -> 3-byte packets -> clamped cursor position and buttons.
// Optional odd-parity checking is enabled by defining MOUSE_PARITY_CHECK_EN.
module ps2_mouse_decoder #(
  parameter int HOR_PIXELS     = 800,
  parameter int VER_PIXELS     = 600,
  parameter int TIMEOUT_CYCLES = 40_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        packet_valid,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [13:0] X_MAX = 14'(HOR_PIXELS - 1);
  localparam logic signed [13:0] Y_MAX = 14'(VER_PIXELS - 1);

  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_edge;

  // Synchronisers reset to the idle-high line level so release from reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_edge = r_clk_prev & ~r_clk_s2;

  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // An edge in the expiry cycle wins: the counter clears and the frame carries on.
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) && !w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_edge) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  logic [1:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       w_parity_ok;
  logic       w_byte_done;
  logic       w_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_timeout) begin
      r_state <= S_IDLE;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
        end
        S_PARITY: r_state <= S_STOP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MOUSE_PARITY_CHECK_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_edge && r_state == S_PARITY) begin
      r_parity <= r_dat_s2;
    end
  end

  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_byte_done = w_edge && (r_state == S_STOP) && r_dat_s2 && w_parity_ok;
  assign w_frame_err = w_edge && (r_state == S_STOP) && !(r_dat_s2 && w_parity_ok);

  // Header keeps only the used bits: {y_ovf, x_ovf, y_sign, x_sign, right, left}.
  logic [1:0]  r_byte_idx;
  logic [5:0]  r_hdr;
  logic [7:0]  r_byte1;
  logic signed [13:0] w_dx, w_dy, w_x_sum, w_y_sum;
  logic [11:0] w_x_new, w_y_new;

  assign w_dx    = r_hdr[4] ? 14'sd0 : {{6{r_hdr[2]}}, r_byte1};
  assign w_dy    = r_hdr[5] ? 14'sd0 : {{6{r_hdr[3]}}, r_shift};
  assign w_x_sum = $signed({2'b00, mouse_xpos}) + w_dx;
  assign w_y_sum = $signed({2'b00, mouse_ypos}) - w_dy;

  always_comb begin
    w_x_new = w_x_sum[11:0];
    if (w_x_sum < 14'sd0)      w_x_new = 12'd0;
    else if (w_x_sum > X_MAX)  w_x_new = X_MAX[11:0];
    w_y_new = w_y_sum[11:0];
    if (w_y_sum < 14'sd0)      w_y_new = 12'd0;
    else if (w_y_sum > Y_MAX)  w_y_new = Y_MAX[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx   <= 2'd0;
      r_hdr        <= '0;
      r_byte1      <= '0;
      mouse_xpos   <= '0;
      mouse_ypos   <= '0;
      mouse_left   <= 1'b0;
      mouse_right  <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      if (w_timeout || w_frame_err) begin
        r_byte_idx <= 2'd0;
      end else if (w_byte_done) begin
        case (r_byte_idx)
          2'd0: begin
            if (r_shift[3]) begin
              r_hdr      <= {r_shift[7:4], r_shift[1:0]};
              r_byte_idx <= 2'd1;
            end
          end
          2'd1: begin
            r_byte1    <= r_shift;
            r_byte_idx <= 2'd2;
          end
          default: begin
            r_byte_idx   <= 2'd0;
            mouse_xpos   <= w_x_new;
            mouse_ypos   <= w_y_new;
            mouse_left   <= r_hdr[0];
            mouse_right  <= r_hdr[1];
            packet_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: byte-level packet model, per-cycle output compare, directed and random frames.
module tb_ps2_mouse_decoder;

  localparam int TO   = 200;
  localparam int HALF = 10;
`ifdef MOUSE_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        mouse_left, mouse_right, packet_valid;
  logic [1:0]  dbg_state;

  ps2_mouse_decoder #(.HOR_PIXELS(800), .VER_PIXELS(600), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .packet_valid(packet_valid), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];
  logic [25:0] held = '0;
  int pulses = 0;
  int exp_pulses = 0;

  int mx, my, midx;
  bit ml, mr;
  logic [7:0] mb0, mb1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; ml = 0; mr = 0; midx = 0;
    exp_q.delete();
    held = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    int dx, dy;
    if (!ok) begin
      midx = 0;
    end else if (midx == 0) begin
      if (b[3]) begin mb0 = b; midx = 1; end
    end else if (midx == 1) begin
      mb1 = b; midx = 2;
    end else begin
      dx = mb0[6] ? 0 : (mb0[4] ? int'(mb1) - 256 : int'(mb1));
      dy = mb0[7] ? 0 : (mb0[5] ? int'(b) - 256 : int'(b));
      mx = mx + dx;
      if (mx < 0) mx = 0;
      if (mx > 799) mx = 799;
      my = my - dy;
      if (my < 0) my = 0;
      if (my > 599) my = 599;
      ml = mb0[0]; mr = mb0[1];
      exp_q.push_back({mx[11:0], my[11:0], ml, mr});
      exp_pulses++;
      midx = 0;
    end
  endtask

  // Model is updated before the frame goes out so the expectation is queued ahead of the pulse.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic [10:0] f;
    model_byte(b, !bad_stop && !(bad_par && PAR_EN));
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat ($urandom_range(HALF, 3 * HALF)) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_xpos", int'(mouse_xpos), 0);
    chk("reset_ypos", int'(mouse_ypos), 0);
    chk("reset_buttons", int'({mouse_left, mouse_right}), 0);
    chk("reset_valid", int'(packet_valid), 0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic lit(input int x, input int y, input int l, input int r);
    @(negedge clk);
    chk("lit_xpos", int'(mouse_xpos), x);
    chk("lit_ypos", int'(mouse_ypos), y);
    chk("lit_left", int'(mouse_left), l);
    chk("lit_right", int'(mouse_right), r);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (packet_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=1 expected=0");
        end else begin
          held = exp_q.pop_front();
          pulses++;
        end
      end
      checks++;
      if ({mouse_xpos, mouse_ypos, mouse_left, mouse_right} !== held) begin
        errors++;
        $display("FAIL outputs actual x=%0d y=%0d l=%0d r=%0d expected x=%0d y=%0d l=%0d r=%0d",
                 mouse_xpos, mouse_ypos, mouse_left, mouse_right,
                 held[25:14], held[13:2], held[1], held[0]);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] b;
    do_reset();

    send_pkt(8'h09, 8'h0A, 8'h05);
    lit(10, 0, 1, 0);

    send_pkt(8'h28, 8'hC3, 8'h6A);
    send_pkt(8'h28, 8'hC3, 8'h6A);
    lit(400, 300, 0, 0);
    send_pkt(8'h38, 8'hF6, 8'hFB);
    lit(390, 305, 0, 0);

    send_pkt(8'h08, 8'hFF, 8'hFF);
    send_pkt(8'h08, 8'h96, 8'h30);
    lit(795, 2, 0, 0);
    send_pkt(8'h08, 8'h14, 8'h0A);
    lit(799, 0, 0, 0);

    p0 = pulses;
    send_frame(8'h00, 1'b0, 1'b0);
    send_pkt(8'h0A, 8'h01, 8'h00);
    lit(799, 0, 0, 1);
    chk("resync_pulses", pulses - p0, 1);

    p0 = pulses;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0);
    repeat (TO * 3 / 2) @(posedge clk);
    midx = 0;
    send_pkt(8'h18, 8'hFD, 8'h02);
    lit(796, 0, 0, 0);
    chk("timeout_pulses", pulses - p0, 1);

    send_pkt(8'hC9, 8'h50, 8'h40);
    lit(796, 0, 1, 0);

    p0 = pulses;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b1);
    send_frame(8'h03, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    chk("parity_pulses", pulses - p0, PAR_EN ? 0 : 1);
    send_pkt(8'h08, 8'h02, 8'h00);

    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h00);

    for (int i = 0; i < 5; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    do_reset();
    send_pkt(8'h29, 8'h03, 8'hFE);
    lit(3, 2, 1, 0);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom_range(0, 255));
        if (k == 0) begin
          if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
          if ($urandom_range(0, 7) != 0) b[7:6] = 2'b00;
        end
        send_frame(b, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      end
    end
    repeat (30) @(posedge clk);

    chk("pulse_count", pulses, exp_pulses);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
